// File: rtl/psum_pkg.sv
// Shared encodings and default sizing for the psum ping-pong store.
package psum_pkg;

  localparam int PSUM_BW_DEF = 32;
  localparam int COL_DEF     = 8;
  localparam int DEPTH_DEF   = 16;
  localparam int ADDR_W_DEF  = 11;
  localparam int PSUM_VEC_W  = PSUM_BW_DEF * COL_DEF;

  typedef enum logic [1:0] {
    MODE_FIRST = 2'd0,
    MODE_ACCUM = 2'd1,
    MODE_DUMP  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // A length of zero or beyond the bank depth means a full bank.
  function automatic int clamp_len(input int len, input int depth);
    if (len == 0 || len > depth) begin
      return depth;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/psum_pingpong_ctrl_if.sv
// Handshake/data bundle between the SFU/output path and the psum ping-pong store.
interface psum_pingpong_ctrl_if #(
  parameter int VEC_W  = psum_pkg::PSUM_VEC_W,
  parameter int ADDR_W = psum_pkg::ADDR_W_DEF
);
  logic              start_pass;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] nij_len;
  logic              rd_req;
  logic [VEC_W-1:0]  psum_rd_data;
  logic              psum_rd_vld;
  logic              in_valid;
  logic              in_ready;
  logic [VEC_W-1:0]  in_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [VEC_W-1:0]  dump_data;
  logic              rchip;
  logic              busy;
  logic              pass_done;
  logic              err;

  modport slave (
    input  start_pass, mode, nij_len, rd_req, in_valid, in_data, dump_ready,
    output psum_rd_data, psum_rd_vld, in_ready, dump_valid, dump_data,
           rchip, busy, pass_done, err
  );

  modport master (
    output start_pass, mode, nij_len, rd_req, in_valid, in_data, dump_ready,
    input  psum_rd_data, psum_rd_vld, in_ready, dump_valid, dump_data,
           rchip, busy, pass_done, err
  );
endinterface

// File: rtl/psum_bank.sv
// One psum bank: COL side-by-side 32-bit SRAMs sharing enable, write-enable and address.
module psum_bank #(
  parameter int COL   = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              i_clk,
  input  logic              i_cen,
  input  logic              i_wen,
  input  logic [AW-1:0]     i_addr,
  input  logic [32*COL-1:0] i_data,
  output logic [32*COL-1:0] o_q
);
  for (genvar g = 0; g < COL; g++) begin : g_col
    sram_32b #(.num(DEPTH), .A_W(AW)) u_sram (
      .CLK (i_clk),
      .CEN (i_cen),
      .WEN (i_wen),
      .A   (i_addr),
      .D   (i_data[g*32 +: 32]),
      .Q   (o_q[g*32 +: 32])
    );
  end
endmodule

// File: rtl/sram_32b.sv
// Single-port 32-bit SRAM model: active-low CEN/WEN, registered read data.
module sram_32b #(
  parameter int num = 16,
  parameter int A_W = 4
) (
  input  logic           CLK,
  input  logic           CEN,
  input  logic           WEN,
  input  logic [A_W-1:0] A,
  input  logic [31:0]    D,
  output logic [31:0]    Q
);
  logic [31:0] r_mem [num];

  // Read or write one word per enabled cycle.
  always_ff @(posedge CLK) begin
    if (!CEN && WEN) begin
      Q <= r_mem[A];
    end
    if (!CEN && !WEN) begin
      r_mem[A] <= D;
    end
  end
endmodule

// File: rtl/psum_pingpong_ctrl.sv
// Double-buffered psum store: FIRST/ACCUM passes write the idle bank and swap at pass end,
// DUMP streams the read bank through a 2-entry skid buffer that hides the 1-cycle read latency.
module psum_pingpong_ctrl
  import psum_pkg::*;
#(
  parameter int PSUM_BW = PSUM_BW_DEF,
  parameter int COL     = COL_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input logic                 clk,
  input logic                 reset,
  psum_pingpong_ctrl_if.slave bus
);
  localparam int VEC_W   = PSUM_BW * COL;
  localparam int BANK_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e            r_state;
  mode_e             r_mode;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic              r_rchip;
  logic              r_err;
  logic              r_pass_done;
  logic              r_acc_vld;
  logic              r_dump_inflight;
  logic [VEC_W-1:0]  r_skid [2];
  logic              r_skid_head;
  logic [1:0]        r_skid_cnt;

  logic              w_run;
  logic              w_busy;
  logic              w_in_ready;
  logic              w_wr_fire;
  logic              w_rd_fire;
  logic              w_dump_valid;
  logic              w_dump_pop;
  logic              w_skid_push;
  logic              w_all_issued;
  logic              w_drain_done;
  logic              w_err_set;
  logic [2:0]        w_skid_occ;
  logic [1:0]        w_skid_cnt_nxt;
  logic [ADDR_W-1:0] w_rd_ptr_nxt;
  logic [ADDR_W-1:0] w_wr_ptr_nxt;
  logic [1:0]        w_cen;
  logic [1:0]        w_wen;
  logic [BANK_AW-1:0] w_addr [2];
  logic [VEC_W-1:0]  w_q [2];
  logic [VEC_W-1:0]  w_rd_q;

  assign w_run        = (r_state == ST_RUN);
  assign w_busy       = (r_state != ST_IDLE);
  assign w_in_ready   = w_run && (r_mode != MODE_DUMP) && (r_wr_ptr < r_len);
  assign w_wr_fire    = w_in_ready && bus.in_valid;
  assign w_dump_valid = (r_skid_cnt != 2'd0);
  assign w_dump_pop   = w_dump_valid && bus.dump_ready;
  assign w_skid_push  = r_dump_inflight;

  // Occupancy the skid would reach if nothing pops next cycle; a new read must still fit.
  assign w_skid_occ     = {1'b0, r_skid_cnt} + {2'b00, r_dump_inflight} - {2'b00, w_dump_pop};
  assign w_skid_cnt_nxt = r_skid_cnt + {1'b0, w_skid_push} - {1'b0, w_dump_pop};

  assign w_rd_fire = w_run && (r_rd_ptr < r_len) &&
                     (((r_mode == MODE_ACCUM) && bus.rd_req) ||
                      ((r_mode == MODE_DUMP) && (w_skid_occ < 3'd2)));

  assign w_rd_ptr_nxt = r_rd_ptr + {{(ADDR_W-1){1'b0}}, w_rd_fire};
  assign w_wr_ptr_nxt = r_wr_ptr + {{(ADDR_W-1){1'b0}}, w_wr_fire};

  assign w_err_set = (bus.start_pass && w_busy) ||
                     (w_busy && bus.in_valid && !w_in_ready) ||
                     (w_busy && (r_mode == MODE_ACCUM) && bus.rd_req && (r_rd_ptr == r_len)) ||
                     (!w_busy && bus.start_pass && (bus.mode == MODE_RSVD));

  // Pass completion conditions per mode.
  always_comb begin
    w_all_issued = 1'b0;
    w_drain_done = 1'b1;
    case (r_mode)
      MODE_ACCUM: begin
        w_all_issued = (w_rd_ptr_nxt == r_len) && (w_wr_ptr_nxt == r_len);
      end
      MODE_DUMP: begin
        w_all_issued = (w_rd_ptr_nxt == r_len);
        w_drain_done = (w_skid_cnt_nxt == 2'd0) && !r_dump_inflight;
      end
      default: begin
        w_all_issued = (w_wr_ptr_nxt == r_len);
      end
    endcase
  end

  // Bank rchip serves reads, the other bank takes writes.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      if (r_rchip == 1'(b)) begin
        w_cen[b]  = ~w_rd_fire;
        w_wen[b]  = 1'b1;
        w_addr[b] = r_rd_ptr[BANK_AW-1:0];
      end else begin
        w_cen[b]  = ~w_wr_fire;
        w_wen[b]  = 1'b0;
        w_addr[b] = r_wr_ptr[BANK_AW-1:0];
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    psum_bank #(.COL(COL), .DEPTH(DEPTH), .AW(BANK_AW)) u_bank (
      .i_clk  (clk),
      .i_cen  (w_cen[g]),
      .i_wen  (w_wen[g]),
      .i_addr (w_addr[g]),
      .i_data (bus.in_data),
      .o_q    (w_q[g])
    );
  end

  assign w_rd_q = r_rchip ? w_q[1] : w_q[0];

  // Pass FSM, pointers, bank select and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_mode          <= MODE_FIRST;
      r_len           <= '0;
      r_rd_ptr        <= '0;
      r_wr_ptr        <= '0;
      r_rchip         <= 1'b0;
      r_err           <= 1'b0;
      r_pass_done     <= 1'b0;
      r_acc_vld       <= 1'b0;
      r_dump_inflight <= 1'b0;
    end else begin
      r_pass_done     <= 1'b0;
      r_acc_vld       <= w_rd_fire && (r_mode == MODE_ACCUM);
      r_dump_inflight <= w_rd_fire && (r_mode == MODE_DUMP);
      r_rd_ptr        <= w_rd_ptr_nxt;
      r_wr_ptr        <= w_wr_ptr_nxt;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.start_pass) begin
            r_state  <= ST_RUN;
            r_mode   <= (bus.mode == MODE_RSVD) ? MODE_FIRST : mode_e'(bus.mode);
            r_len    <= ADDR_W'(clamp_len(int'(bus.nij_len), DEPTH));
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
          end
        end
        ST_RUN: begin
          if (w_all_issued) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_drain_done) begin
            r_state     <= ST_IDLE;
            r_pass_done <= 1'b1;
            if (r_mode != MODE_DUMP) begin
              r_rchip <= ~r_rchip;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // DUMP skid buffer: captures read data as it returns, releases it under dump_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_skid[0]   <= '0;
      r_skid[1]   <= '0;
      r_skid_head <= 1'b0;
      r_skid_cnt  <= 2'd0;
    end else begin
      if (w_skid_push) begin
        r_skid[r_skid_head ^ r_skid_cnt[0]] <= w_rd_q;
      end
      if (w_dump_pop) begin
        r_skid_head <= ~r_skid_head;
      end
      r_skid_cnt <= w_skid_cnt_nxt;
    end
  end

  assign bus.psum_rd_vld  = r_acc_vld;
  assign bus.psum_rd_data = r_acc_vld ? w_rd_q : '0;
  assign bus.in_ready     = w_in_ready;
  assign bus.dump_valid   = w_dump_valid;
  assign bus.dump_data    = w_dump_valid ? r_skid[r_skid_head] : '0;
  assign bus.rchip        = r_rchip;
  assign bus.busy         = w_busy;
  assign bus.pass_done    = r_pass_done;
  assign bus.err          = r_err;
endmodule
